// File: rtl/bus_grant_arbiter.sv
// Round-robin arbiter granting one of N_SRC bus sources as a registered one-hot vector.
// One-cycle request-to-grant; back-to-back handoff on release; watchdog forces release after MAX_OWN cycles.
module bus_grant_arbiter #(
    parameter int N_SRC   = 24,
    parameter int MAX_OWN = 15
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic [N_SRC-1:0] i_req,
    input  logic             i_done,
    input  logic             i_hold,
    output logic [N_SRC-1:0] o_grant,
    output logic             o_grant_valid,
    output logic             o_timeout
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [7:0] CNT_MAX = 8'(MAX_OWN);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_own;
    logic [7:0]       r_cnt;
    logic [N_SRC-1:0] r_grant;
    logic             r_grant_valid;
    logic             r_timeout;

    logic [IW-1:0]    w_sel_ptr;
    logic [IW-1:0]    w_next_start;
    logic [IW-1:0]    w_sel_next;
    logic             w_others;
    logic             w_owner_req;
    logic             w_watchdog;
    logic             w_release;

    // First requester at or after p, wrapping at N_SRC rather than at the index width.
    function automatic logic [IW-1:0] f_sel(input logic [N_SRC-1:0] req, input logic [IW-1:0] p);
        logic [IW-1:0]    res;
        logic             hit;
        logic [N_SRC-1:0] mask;
        int               idx;
        res = '0;
        hit = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(p) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            mask = N_SRC'(1) << idx;
            if (!hit && ((req & mask) != '0)) begin
                res = IW'(idx);
                hit = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [N_SRC-1:0] f_onehot(input logic [IW-1:0] idx);
        return N_SRC'(1) << idx;
    endfunction

    always_comb begin
        w_next_start = (r_own == IW'(N_SRC - 1)) ? '0 : r_own + IW'(1);
        w_sel_ptr    = f_sel(i_req, r_ptr);
        w_sel_next   = f_sel(i_req, w_next_start);
        // The grant register is the owner's one-hot, so it doubles as the owner mask.
        w_owner_req  = (i_req & r_grant) != '0;
        w_others     = (i_req & ~r_grant) != '0;
        w_watchdog   = (r_cnt == CNT_MAX);
        w_release    = i_done || !w_owner_req || w_watchdog;
    end

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_own         <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else if (!i_hold) begin
            case (r_state)
                IDLE: begin
                    if (i_req != '0) begin
                        r_own         <= w_sel_ptr;
                        r_grant       <= f_onehot(w_sel_ptr);
                        r_grant_valid <= 1'b1;
                        r_cnt         <= 8'd1;
                        r_state       <= OWN;
                    end else begin
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                    end
                end
                OWN: begin
                    if (w_release) begin
                        r_ptr <= w_next_start;
                        if (w_watchdog) r_timeout <= 1'b1;
                        if (w_others) begin
                            r_own         <= w_sel_next;
                            r_grant       <= f_onehot(w_sel_next);
                            r_grant_valid <= 1'b1;
                            r_cnt         <= 8'd1;
                        end else begin
                            r_grant       <= '0;
                            r_grant_valid <= 1'b0;
                            r_cnt         <= '0;
                            r_state       <= IDLE;
                        end
                    end else if (!w_watchdog) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_valid = r_grant_valid;
    assign o_timeout     = r_timeout;

endmodule
